// File: rtl/regwr_pkg.sv
// Shared widths, source-select encodings and the buffered-result entry type
// for the register-file write arbiter.
package regwr_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic SRC_WB = 1'b0;
    localparam logic SRC_MC = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rw_entry_t;

    // True when a live, still-valid entry targets a nonzero source register
    function automatic logic addr_hit(input rw_entry_t e, input logic [ADDR_W-1:0] a);
        return e.valid && (a != '0) && (e.addr == a);
    endfunction

endpackage

// File: rtl/regwr_fifo2.sv
// Two-entry FIFO of buffered multi-cycle results with kill-by-address
// invalidation and per-entry source-register match outputs.
module regwr_fifo2
    import regwr_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              push,
    input  rw_entry_t         push_entry,
    input  logic              pop,
    input  logic              kill,
    input  logic [ADDR_W-1:0] kill_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output rw_entry_t         head,
    output logic [CNT_W-1:0]  count,
    output logic [1:0]        match_rs,
    output logic [1:0]        match_rt
);

    rw_entry_t mem [FIFO_DEPTH];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      push_ok;
    logic      pop_ok;

    assign push_ok = push && (count != CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop  && (count != '0);

    // Popped slots lose valid so that valid alone marks a live, unkilled entry
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push_ok && (wr_ptr == 1'(i))) begin
                    mem[i] <= push_entry;
                end else if (pop_ok && (rd_ptr == 1'(i))) begin
                    mem[i].valid <= 1'b0;
                end else if (kill && (mem[i].addr == kill_addr)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            match_rs[i] = addr_hit(mem[i], rs_addr);
            match_rt[i] = addr_hit(mem[i], rt_addr);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and
// out-of-band multi-cycle results, buffering the latter and requesting stalls.
module regfile_write_arbiter
    import regwr_pkg::*;
#(
    parameter int unsigned DATA_W     = regwr_pkg::DATA_W,
    parameter int unsigned ADDR_W     = regwr_pkg::ADDR_W,
    parameter int unsigned STARVE_MAX = regwr_pkg::STARVE_MAX
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              haz_rs,
    output logic              haz_rt,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_src_sel,
    output logic              stall_req
);

    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

    rw_entry_t         head;
    rw_entry_t         push_entry;
    logic [CNT_W-1:0]  count;
    logic [1:0]        match_rs;
    logic [1:0]        match_rt;
    logic              wb_grant;
    logic              accept;
    logic              pop;
    logic              bypass;
    logic              store;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_nxt;

    // Ready is forced low while reset is asserted so every output reads zero
    assign mc_ready = Rst_n && (count != CNT_W'(FIFO_DEPTH));

    always_comb begin
        wb_grant = Rst_n && wb_we && (wb_addr != '0);
        accept   = mc_valid && mc_ready;
        pop      = !wb_grant && (count != '0);
        bypass   = !wb_grant && (count == '0) && accept && (mc_addr != '0);
        store    = accept && !bypass && (mc_addr != '0);
    end

    assign push_entry = '{valid: 1'b1, addr: mc_addr, data: mc_data};

    regwr_fifo2 u_fifo (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .push       (store),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (wb_grant),
        .kill_addr  (wb_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .head       (head),
        .count      (count),
        .match_rs   (match_rs),
        .match_rt   (match_rt)
    );

    // Write-port mux: WB first, then buffered head, then empty-FIFO bypass
    always_comb begin
        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_data    = '0;
        rf_src_sel = SRC_WB;
        if (wb_grant) begin
            rf_we      = 1'b1;
            rf_addr    = wb_addr;
            rf_data    = wb_data;
            rf_src_sel = SRC_WB;
        end else if (pop) begin
            rf_we      = head.valid;
            rf_addr    = head.addr;
            rf_data    = head.data;
            rf_src_sel = SRC_MC;
        end else if (bypass) begin
            rf_we      = 1'b1;
            rf_addr    = mc_addr;
            rf_data    = mc_data;
            rf_src_sel = SRC_MC;
        end
    end

    assign haz_rs = |match_rs;
    assign haz_rt = |match_rt;

    // Blocked-head age, saturating, cleared whenever the head drains
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop) begin
            starve_nxt = '0;
        end else if ((count != '0) && (starve_cnt != SC_W'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == SC_W'(STARVE_MAX));
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_regfile_write_arbiter;

    localparam int STARVE = 4;

    logic        Clk;
    logic        Rst_n;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        haz_rs;
    logic        haz_rt;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_src_sel;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .haz_rs     (haz_rs),
        .haz_rt     (haz_rt),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .rf_src_sel (rf_src_sel),
        .stall_req  (stall_req)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending results in arrival order plus blocked-cycle age
    typedef struct {
        bit        valid;
        bit [4:0]  addr;
        bit [31:0] data;
    } m_ent_t;

    m_ent_t    mq[$];
    int        m_age   = 0;
    bit        m_stall = 1'b0;
    bit        e_wbg, e_ready, e_acc, e_pop, e_byp, e_we, e_sel, e_hrs, e_hrt;
    bit [4:0]  e_addr;
    bit [31:0] e_data;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            chk("rst_rf_we", rf_we, 0);
            chk("rst_rf_src_sel", rf_src_sel, 0);
            chk("rst_rf_addr", rf_addr, 0);
            chk("rst_rf_data", rf_data, 0);
            chk("rst_mc_ready", mc_ready, 0);
            chk("rst_haz", {haz_rs, haz_rt}, 0);
            chk("rst_stall_req", stall_req, 0);
            mq.delete();
            m_age   = 0;
            m_stall = 1'b0;
        end else begin
            e_wbg   = wb_we && (wb_addr != 0);
            e_ready = (mq.size() < 2);
            e_acc   = mc_valid && e_ready;
            e_pop   = !e_wbg && (mq.size() > 0);
            e_byp   = !e_wbg && (mq.size() == 0) && e_acc && (mc_addr != 0);
            e_we = 0; e_sel = 0; e_addr = 0; e_data = 0;
            if (e_wbg) begin
                e_we = 1; e_addr = wb_addr; e_data = wb_data;
            end else if (e_pop) begin
                e_we = mq[0].valid; e_sel = 1; e_addr = mq[0].addr; e_data = mq[0].data;
            end else if (e_byp) begin
                e_we = 1; e_sel = 1; e_addr = mc_addr; e_data = mc_data;
            end
            e_hrs = 0; e_hrt = 0;
            foreach (mq[i]) begin
                if (mq[i].valid && rs_addr != 0 && mq[i].addr == rs_addr) e_hrs = 1;
                if (mq[i].valid && rt_addr != 0 && mq[i].addr == rt_addr) e_hrt = 1;
            end
            chk("m_rf_we", rf_we, e_we);
            chk("m_rf_src_sel", rf_src_sel, e_sel);
            if (e_we) begin
                chk("m_rf_addr", rf_addr, e_addr);
                chk("m_rf_data", rf_data, e_data);
            end
            chk("m_mc_ready", mc_ready, e_ready);
            chk("m_haz_rs", haz_rs, e_hrs);
            chk("m_haz_rt", haz_rt, e_hrt);
            chk("m_stall_req", stall_req, m_stall);
            // advance to the state seen after the coming edge
            if (e_wbg) begin
                foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].valid = 0;
            end
            if (e_pop) begin
                void'(mq.pop_front());
                m_age = 0;
            end else if (mq.size() > 0) begin
                m_age = (m_age + 1 > STARVE) ? STARVE : m_age + 1;
            end
            if (e_acc && !e_byp && mc_addr != 0) mq.push_back('{1'b1, mc_addr, mc_data});
            m_stall = (m_age == STARVE);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic see();
        @(negedge Clk);
    endtask

    task automatic drive(input bit w, input bit [4:0] wa, input bit [31:0] wd,
                         input bit m, input bit [4:0] ma, input bit [31:0] md);
        wb_we = w; wb_addr = wa; wb_data = wd;
        mc_valid = m; mc_addr = ma; mc_data = md;
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(1, 4, 32'h55, 1, 6, 32'h1);
        rs_addr = 0; rt_addr = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_mc_ready", mc_ready, 0);
        Rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("post_reset_mc_ready", mc_ready, 1);
        tick();

        // bypass into an empty FIFO
        drive(0, 0, 0, 1, 5, 32'h1234);
        see();
        chk("byp_rf_we", rf_we, 1);
        chk("byp_rf_addr", rf_addr, 5);
        chk("byp_rf_data", rf_data, 32'h1234);
        chk("byp_rf_src_sel", rf_src_sel, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rs_addr = 5;
        see();
        chk("byp_empty_rf_we", rf_we, 0);
        chk("byp_no_haz", haz_rs, 0);
        tick();

        // contention: WB wins, mc result buffered then drained
        drive(1, 3, 32'haa, 1, 7, 32'h77);
        rs_addr = 7;
        see();
        chk("cont_wb_addr", rf_addr, 3);
        chk("cont_wb_sel", rf_src_sel, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("cont_haz_rs", haz_rs, 1);
        chk("cont_drain_addr", rf_addr, 7);
        chk("cont_drain_data", rf_data, 32'h77);
        chk("cont_drain_sel", rf_src_sel, 1);
        tick();
        see();
        chk("cont_haz_clear", haz_rs, 0);
        rs_addr = 0;
        tick();

        // full FIFO refuses a third result until a pop
        drive(1, 1, 32'h11, 1, 10, 32'ha0);
        tick();
        drive(1, 1, 32'h12, 1, 11, 32'hb0);
        tick();
        drive(1, 1, 32'h13, 1, 12, 32'hc0);
        see();
        chk("full_ready_c", mc_ready, 0);
        tick();
        see();
        chk("full_ready_d", mc_ready, 0);
        tick();
        drive(0, 0, 0, 1, 12, 32'hc0);
        see();
        chk("full_pop_addr", rf_addr, 10);
        chk("full_pop_ready", mc_ready, 0);
        tick();
        see();
        chk("full_pop2_addr", rf_addr, 11);
        chk("full_pop2_ready", mc_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("full_pop3_addr", rf_addr, 12);
        chk("full_pop3_data", rf_data, 32'hc0);
        tick();

        // starvation: one entry blocked by continuous WB
        drive(1, 2, 32'h22, 1, 8, 32'h88);
        tick();
        drive(1, 2, 32'h23, 0, 0, 0);
        for (int i = 0; i < STARVE; i++) begin
            see();
            chk("starve_low", stall_req, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("starve_high", stall_req, 1);
        chk("starve_drain_addr", rf_addr, 8);
        tick();
        see();
        chk("starve_fall", stall_req, 0);
        tick();

        // kill: WB overwrites a buffered destination
        drive(1, 2, 32'h22, 1, 9, 32'h99);
        tick();
        drive(1, 9, 32'h55, 0, 0, 0);
        rt_addr = 9;
        see();
        chk("kill_haz_before", haz_rt, 1);
        chk("kill_wb_addr", rf_addr, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("kill_haz_rt", haz_rt, 0);
        chk("kill_pop_we", rf_we, 0);
        chk("kill_pop_sel", rf_src_sel, 1);
        tick();
        rt_addr = 0;
        drive(0, 0, 0, 1, 0, 32'hdead);
        see();
        chk("r0_we", rf_we, 0);
        chk("r0_ready", mc_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("r0_not_stored", rf_src_sel, 0);
        tick();

        // reset with two buffered entries
        drive(1, 1, 32'h1, 1, 12, 32'h12);
        tick();
        drive(1, 1, 32'h2, 1, 13, 32'h13);
        tick();
        drive(1, 1, 32'h3, 0, 0, 0);
        rs_addr = 12;
        #1;
        chk("rst2_haz_before", haz_rs, 1);
        chk("rst2_ready_before", mc_ready, 0);
        Rst_n = 1'b0;
        #1;
        chk("rst2_rf_we", rf_we, 0);
        chk("rst2_rf_addr", rf_addr, 0);
        chk("rst2_mc_ready", mc_ready, 0);
        chk("rst2_haz", haz_rs, 0);
        tick();
        Rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        see();
        chk("rst2_after_ready", mc_ready, 1);
        chk("rst2_after_empty", rf_we, 0);
        tick();
        rs_addr = 0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wb_we    = ($urandom_range(0, 99) < 60) && !stall_req;
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            mc_valid = ($urandom_range(0, 99) < 50);
            mc_addr  = 5'($urandom_range(0, 7));
            mc_data  = $urandom;
            rs_addr  = 5'($urandom_range(0, 7));
            rt_addr  = 5'($urandom_range(0, 7));
            tick();
        end
        see();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
